// File: rtl/reg_write_arbiter.sv
// Arbitrates the two-pipeline block-register write port between host writes and FIFO-buffered modulation writes.
// Optional auto-commit after a modulation burst drains: define REG_ARB_AUTOCOMMIT_EN.
module reg_write_arbiter #(
   parameter int N_BLOCKS       = 256,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int MOD_FIFO_DEPTH = 4,
   localparam int BW            = $clog2(N_BLOCKS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      host_req,
   input  logic                      host_pipeline,
   input  logic [BW-1:0]             host_block,
   input  logic [REG_ADDR_WIDTH-1:0] host_reg,
   input  logic [DATA_WIDTH-1:0]     host_data,
   output logic                      host_ack,
   input  logic                      mod_valid,
   input  logic [BW-1:0]             mod_block,
   input  logic [REG_ADDR_WIDTH-1:0] mod_reg,
   input  logic [DATA_WIDTH-1:0]     mod_data,
   output logic                      mod_ready,
   input  logic                      pipelines_swapping,
   input  logic [1:0]                pipeline_regfiles_syncing,
   output logic [BW-1:0]             block_target,
   output logic [REG_ADDR_WIDTH-1:0] reg_target,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic [1:0]                block_reg_write,
   output logic [1:0]                reg_writes_commit,
   output logic [1:0]                state_dbg
);

   localparam int PW = $clog2(MOD_FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(MOD_FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

`ifdef REG_ARB_AUTOCOMMIT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_COMMIT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1} state_t;
`endif

   state_t state, next_state;

   logic [BW-1:0]             fifo_block [MOD_FIFO_DEPTH];
   logic [REG_ADDR_WIDTH-1:0] fifo_reg   [MOD_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     fifo_data  [MOD_FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             count;
   logic                      full, empty, push, pop;

   logic stall_h, stall_m, eligible_h, eligible_m;
   logic take_host, take_mod;
   logic last_grant_host, grant_host, tgt_pipe;

   // mod_valid/mod_ready: a word moves on any edge where both are high; the
   // source holds its word stable until then. mod_ready comes from the
   // registered count only, so a full FIFO refuses even while popping.
   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign mod_ready = ~full;
   assign push      = mod_valid & ~full;
   assign pop       = (state == S_ISSUE) & ~grant_host;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_block[wr_ptr] <= mod_block;
         fifo_reg[wr_ptr]   <= mod_reg;
         fifo_data[wr_ptr]  <= mod_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign stall_h    = pipelines_swapping | pipeline_regfiles_syncing[host_pipeline];
   assign stall_m    = pipelines_swapping | pipeline_regfiles_syncing[0];
   assign eligible_h = host_req & ~stall_h;
   assign eligible_m = ~empty & ~stall_m;

   always_comb begin
      next_state = state;
      take_host  = 1'b0;
      take_mod   = 1'b0;
      case (state)
         S_IDLE: begin
            if (eligible_h && eligible_m) begin
               take_host = ~last_grant_host;
               take_mod  = last_grant_host;
            end else begin
               take_host = eligible_h;
               take_mod  = eligible_m;
            end
            if (take_host || take_mod) next_state = S_ISSUE;
         end
         S_ISSUE: begin
            next_state = S_IDLE;
`ifdef REG_ARB_AUTOCOMMIT_EN
            // Commit once the burst has drained: this pop empties the FIFO.
            if (!grant_host && count == ONE_COUNT && !push) next_state = S_COMMIT;
`endif
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         last_grant_host <= 1'b0;
         grant_host      <= 1'b0;
         tgt_pipe        <= 1'b0;
         block_target    <= '0;
         reg_target      <= '0;
         data_out        <= '0;
      end else begin
         state <= next_state;
         if (take_host) begin
            block_target    <= host_block;
            reg_target      <= host_reg;
            data_out        <= host_data;
            tgt_pipe        <= host_pipeline;
            grant_host      <= 1'b1;
            last_grant_host <= 1'b1;
         end else if (take_mod) begin
            block_target    <= fifo_block[rd_ptr];
            reg_target      <= fifo_reg[rd_ptr];
            data_out        <= fifo_data[rd_ptr];
            tgt_pipe        <= 1'b0;
            grant_host      <= 1'b0;
            last_grant_host <= 1'b0;
         end
      end
   end

   assign block_reg_write = (state == S_ISSUE) ? (tgt_pipe ? 2'b10 : 2'b01) : 2'b00;
   assign host_ack        = (state == S_ISSUE) & grant_host;
   assign state_dbg       = state;

`ifdef REG_ARB_AUTOCOMMIT_EN
   logic mod_dirty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  mod_dirty <= 1'b0;
      else if (pop)               mod_dirty <= 1'b1;
      else if (state == S_COMMIT) mod_dirty <= 1'b0;
   end

   assign reg_writes_commit = {1'b0, (state == S_COMMIT) & mod_dirty};
`else
   assign reg_writes_commit = 2'b00;
`endif

endmodule
